// File: rtl/alu_ctrl.sv
// Register-file front end for a downstream ALU: accept command, wait for result, write back.
// Optional flag outputs (flag_z, flag_n) are enabled by defining ALU_CTRL_FLAGS_EN.
module alu_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [2:0]  cmd_ra,
   input  logic [2:0]  cmd_rb,
   input  logic [2:0]  cmd_rd,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [2:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_opdone,
   output logic        done,
   output logic        err,
   output logic [31:0] result,
`ifdef ALU_CTRL_FLAGS_EN
   output logic        flag_z,
   output logic        flag_n,
`endif
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t           state, state_nxt;
   logic [7:0][31:0] regs;
   logic [2:0]       rd_q;
   logic             accept, capture, illegal;

   assign accept  = (state == IDLE) && cmd_valid;
   assign capture = (state == EXEC) && alu_opdone;
   assign illegal = (alu_op >= 4'hD);
   assign rd_data = regs[rd_addr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = EXEC;
         EXEC:    if (alu_opdone) state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == WB);
      err       = (state == WB) && illegal;
   end

   // alu_a/alu_b/alu_op double as the latched operands, so they hold outside EXEC
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         rd_q   <= '0;
      end else if (accept) begin
         alu_a  <= regs[cmd_ra];
         alu_b  <= regs[cmd_rb];
         alu_op <= cmd_op;
         rd_q   <= cmd_rd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) result <= '0;
      else if (capture) result <= alu_result;
   end

`ifdef ALU_CTRL_FLAGS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (capture) begin
         flag_z <= (alu_result == 32'h0);
         flag_n <= alu_result[31];
      end
   end
`endif

   // Write-back is ordered after the external write so it wins on an address clash
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) regs <= '0;
      else begin
         if (wr_en) regs[wr_addr] <= wr_data;
         if ((state == WB) && !illegal) regs[rd_q] <= result;
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed scenarios plus randomized traffic vs a transaction model.
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_op;
   logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
   logic        wr_en;
   logic [2:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   logic [31:0] alu_a, alu_b, alu_result, result;
   logic [3:0]  alu_op;
   logic        alu_opdone, done, err, busy;
`ifdef ALU_CTRL_FLAGS_EN
   logic        flag_z, flag_n;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_opdone(alu_opdone),
      .done(done), .err(err), .result(result),
`ifdef ALU_CTRL_FLAGS_EN
      .flag_z(flag_z), .flag_n(flag_n),
`endif
      .busy(busy)
   );

   // Transaction-level model: phase 0 = free, 1 = waiting on ALU, 2 = completing
   logic [31:0] m_reg [8];
   logic [31:0] m_a, m_b, m_res;
   logic [3:0]  m_op;
   logic [2:0]  m_rd;
   int          m_ph;
   logic        m_fz, m_fn;

   function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         4'hB:    return a + b;
         4'hC:    return a - b;
         default: return a ^ (b + {28'h0, op});
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_rd = '0;
      m_ph = 0; m_fz = 1'b0; m_fn = 1'b0;
   endtask

   task automatic model_step();
      logic wb;
      wb = (m_ph == 2);
      if (m_ph == 0 && cmd_valid) begin
         m_a = m_reg[cmd_ra]; m_b = m_reg[cmd_rb]; m_op = cmd_op; m_rd = cmd_rd;
         m_ph = 1;
      end else if (m_ph == 1 && alu_opdone) begin
         m_res = alu_result; m_fz = (alu_result == 0); m_fn = alu_result[31];
         m_ph = 2;
      end else if (m_ph == 2) begin
         m_ph = 0;
      end
      if (wr_en) m_reg[wr_addr] = wr_data;
      if (wb && m_op < 4'hD) m_reg[m_rd] = m_res;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, m_ph == 0});
      chk("busy",      {31'h0, busy},      {31'h0, m_ph != 0});
      chk("done",      {31'h0, done},      {31'h0, m_ph == 2});
      chk("err",       {31'h0, err},       {31'h0, (m_ph == 2) && (m_op >= 4'hD)});
      chk("result",    result,             m_res);
      chk("alu_a",     alu_a,              m_a);
      chk("alu_b",     alu_b,              m_b);
      chk("alu_op",    {28'h0, alu_op},    {28'h0, m_op});
      chk("rd_data",   rd_data,            m_reg[rd_addr]);
`ifdef ALU_CTRL_FLAGS_EN
      chk("flag_z",    {31'h0, flag_z},    {31'h0, m_fz});
      chk("flag_n",    {31'h0, flag_n},    {31'h0, m_fn});
`endif
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge
   task automatic cycle();
      alu_result = alu_fn(m_op, m_a, m_b);
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_in();
      cmd_valid = 1'b0; wr_en = 1'b0; alu_opdone = 1'b1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] rd);
      cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
      cycle();
      cmd_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
      wr_addr = '0; wr_data = '0; rd_addr = '0; alu_result = '0;
      idle_in();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_result", result, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset_n = 1'b1;
      cycle();

      // Add: 5 + 3 into reg3
      wr(3'd1, 32'd5);
      wr(3'd2, 32'd3);
      issue(4'hB, 3'd1, 3'd2, 3'd3);
      chk("add_no_done_at_accept", {31'h0, done}, 32'h0);
      rd_addr = 3'd3;
      cycle();
      chk("add_done", {31'h0, done}, 32'h1);
      chk("add_result", result, 32'd8);
      cycle();
      chk("add_reg3", rd_data, 32'd8);
      chk("add_ready", {31'h0, cmd_ready}, 32'h1);

      // Subtract: 5 - 3 into reg3
      issue(4'hC, 3'd1, 3'd2, 3'd3);
      cycle();
      cycle();
      chk("sub_reg3", rd_data, 32'd2);

`ifdef ALU_CTRL_FLAGS_EN
      wr(3'd1, 32'd7);
      wr(3'd2, 32'd7);
      issue(4'hC, 3'd1, 3'd2, 3'd4);
      cycle();
      chk("sub_flag_z", {31'h0, flag_z}, 32'h1);
      cycle();
      wr(3'd1, 32'd5);
      wr(3'd2, 32'd3);
`endif

      // Illegal op leaves reg3 alone
      wr(3'd3, 32'd8);
      issue(4'hE, 3'd1, 3'd2, 3'd3);
      cycle();
      chk("ill_done", {31'h0, done}, 32'h1);
      chk("ill_err", {31'h0, err}, 32'h1);
      cycle();
      chk("ill_reg3", rd_data, 32'd8);

      // Stall four cycles; commands offered meanwhile must be ignored
      issue(4'hB, 3'd1, 3'd2, 3'd5);
      alu_opdone = 1'b0;
      cmd_valid = 1'b1; cmd_op = 4'h3; cmd_rd = 3'd6;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("stall_busy", {31'h0, busy}, 32'h1);
         chk("stall_ready", {31'h0, cmd_ready}, 32'h0);
      end
      alu_opdone = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      chk("stall_done", {31'h0, done}, 32'h1);
      chk("stall_result", result, 32'd8);
      cycle();

      // Collision at the write-back edge: same address (WB wins) and different address
      issue(4'hB, 3'd1, 3'd2, 3'd3);
      cycle();
      wr(3'd3, 32'hFFFF_FFFF);
      chk("coll_same_reg3", rd_data, 32'd8);
      issue(4'hB, 3'd1, 3'd2, 3'd3);
      cycle();
      wr(3'd7, 32'h1234_5678);
      rd_addr = 3'd7;
      cycle();
      chk("coll_diff_reg7", rd_data, 32'h1234_5678);

      // Reset during EXEC aborts the command
      wr(3'd1, 32'd5);
      issue(4'hB, 3'd1, 3'd2, 3'd6);
      alu_opdone = 1'b0;
      cycle();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_exec_done", {31'h0, done}, 32'h0);
      chk("rst_exec_busy", {31'h0, busy}, 32'h0);
      alu_opdone = 1'b1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rd_addr = 3'd6;
      cycle();
      chk("rst_exec_reg6", rd_data, 32'h0);
      chk("rst_exec_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_exec_no_done", {31'h0, done}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 8; i++) wr(i[2:0], $urandom);
      for (int n = 0; n < 600; n++) begin
         cmd_valid  = ($urandom_range(0, 2) != 0);
         cmd_op     = 4'($urandom);
         cmd_ra     = 3'($urandom);
         cmd_rb     = 3'($urandom);
         cmd_rd     = 3'($urandom);
         wr_en      = ($urandom_range(0, 3) == 0);
         wr_addr    = (m_ph == 2 && $urandom_range(0, 1) == 1) ? m_rd : 3'($urandom);
         wr_data    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         rd_addr    = 3'($urandom);
         alu_opdone = ($urandom_range(0, 9) < 7);
         cycle();
      end
      idle_in();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset_n as elsewhere in the codebase.
REQ-002 The port list SHALL be:
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  ALU opcode
- cmd_ra  in  3  source register for operand a
- cmd_rb  in  3  source register for operand b
- cmd_rd  in  3  destination register
- wr_en  in  1  external register write strobe
- wr_addr  in  3  external write address
- wr_data  in  32  external write data
- rd_addr  in  3  external read address
- rd_data  out  32  combinational read of reg[rd_addr]
- alu_a  out  32  operand a to the downstream ALU
- alu_b  out  32  operand b to the downstream ALU
- alu_op  out  4  opcode to the downstream ALU
- alu_result  in  32  ALU result
- alu_opdone  in  1  ALU result valid
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-op pulse, coincident with done
- result  out  32  last captured result
- busy  out  1  high whenever state is not IDLE

Function
REQ-003 The block SHALL hold an 8 x 32-bit register file, with all 8 entries writable.
REQ-004 The FSM SHALL have three states: IDLE, EXEC and WB.
REQ-005 cmd_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, when cmd_valid=1, the block SHALL accept at that edge:
- latch op, ra-value, rb-value and rd into internal registers
- go to EXEC.
REQ-007 Operand values SHALL be the array contents before the accept edge; an external write at the same edge is not forwarded.
REQ-008 In EXEC:
- alu_a, alu_b and alu_op SHALL present the latched operands and op
- on an edge with alu_opdone=1: capture alu_result into result and go to WB
- otherwise remain in EXEC, with no timeout.
REQ-009 In WB:
- done=1 for exactly one cycle
- at the WB-exit edge, write result to reg[rd] and return to IDLE.
REQ-010 Latency SHALL be as follows when alu_opdone is held at 1:
- accept at edge k
- capture at edge k+1
- done high in cycle k+1..k+2
- register write at edge k+2
- throughput of one command per 3 cycles.
REQ-011 Opcodes 4'hD–4'hF SHALL be illegal:
- the command still sequences normally
- err=1 with done
- no register write; result still updates to alu_result.
REQ-012 An external write and a WB write to the same address at the same edge SHALL resolve with the WB write winning.
REQ-013 An external write and a WB write to different addresses at the same edge SHALL both take effect.
REQ-014 alu_a, alu_b and alu_op SHALL hold their last values outside EXEC; they do not return to zero.
REQ-015 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-016 On reset_n=0, the block SHALL immediately force:
- state to IDLE
- all 8 registers to 0
- result, alu_a, alu_b to 32'h0
- alu_op to 4'h0
- done, err, busy to 0
- cmd_ready to 1.
REQ-017 A reset asserted in EXEC or WB SHALL abort the command with no register write and no done pulse.

Configuration
REQ-018 With macro ALU_CTRL_FLAGS_EN defined, the block SHALL:
- add outputs flag_z (result==0) and flag_n (result[31])
- register both at the capture edge
- reset both to 0.
REQ-019 Without ALU_CTRL_FLAGS_EN, the flag_z and flag_n ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Add: reg1=5, reg2=3 via wr_en; cmd op=4'hB, ra=1, rb=2, rd=3 -> done at accept+1, result=8, rd_data(3)=8 after edge k+2.
- Subtract: same operands, op=4'hC -> reg3=2; FLAGS_EN build with reg1=reg2=7 -> flag_z=1.
- Illegal op: op=4'hE, rd=3, reg3=8 beforehand -> done=1 and err=1 in the same cycle, reg3 stays 8.
- Stall: alu_opdone held 0 for 4 cycles in EXEC -> busy=1, cmd_ready=0 throughout; capture on the first edge with opdone=1.
- Write collision: wr_en to reg3 with data 32'hFFFF_FFFF at the WB-exit edge of an add producing 8 into reg3 -> reg3=8.
- Reset in EXEC: reset_n low during EXEC -> reg[rd] unchanged (0 after reset), no done pulse, cmd_ready=1 once reset_n rises.
